// File: rtl/axis_frame_source.sv
// -----------------------------------------------------------------------------
// axis_frame_source
//
// AXI-Stream master that plays a frame of samples out of an internal buffer.
// The buffer is loaded through a simple write port while the block is idle.
// A start request then streams the first frame_len samples with full
// tvalid/tready backpressure, and tlast is set on the final beat.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   wr_en/wr_addr/wr_data   buffer write port (honoured only in IDLE)
//   start, frame_len        frame request; frame_len is sampled with start
//   busy           high while a frame is being sent
//   done           one-cycle pulse after the tlast beat is accepted
//   len_err        one-cycle pulse when start carries an illegal frame_len
//   beat_count     beats accepted in the current/last frame
//   m_axis_*       AXI-Stream master interface
// -----------------------------------------------------------------------------
module axis_frame_source #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   frame_len,
    output logic                  busy,
    output logic                  done,
    output logic                  len_err,
    output logic [ADDR_WIDTH:0]   beat_count,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  len_err_q;
    logic [ADDR_WIDTH:0]   beat_count_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;

    // Next read pointer and the tlast flag that goes with the beat it fetches.
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic                  tlast_d;
    logic                  len_ok;
    logic                  handshake;

    assign ptr_d     = ptr_q + 1'b1;
    assign tlast_d   = ({1'b0, ptr_d} == (len_q - 1'b1));
    assign len_ok    = (frame_len != '0) && (frame_len <= MAX_LEN);
    assign handshake = tvalid_q && m_axis_tready;

    // NOTE: the buffer has no reset branch; clearing it would turn the array
    // into thousands of resettable flops instead of a RAM, and its contents
    // are expected to survive a reset anyway.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: every register below is assigned with <= so all state updates
    // read the pre-edge values; blocking assignments here would make results
    // depend on statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            ptr_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            len_err_q    <= 1'b0;
            beat_count_q <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
        end else begin
            // Pulses default low; the branches below raise them for one cycle.
            done_q    <= 1'b0;
            len_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_q        <= frame_len;
                            ptr_q        <= '0;
                            beat_count_q <= '0;
                            tdata_q      <= mem[0];
                            tvalid_q     <= 1'b1;
                            tlast_q      <= (frame_len == 1);
                            busy_q       <= 1'b1;
                            state_q      <= S_SEND;
                        end else begin
                            len_err_q <= 1'b1;
                        end
                    end
                end

                S_SEND: begin
                    // Without a handshake everything holds, so tdata/tlast
                    // stay stable and tvalid cannot drop.
                    if (handshake) begin
                        beat_count_q <= beat_count_q + 1'b1;
                        if (tlast_q) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            // Prefetch the next sample on the accepting edge
                            // so a continuously ready sink sees no bubbles.
                            ptr_q   <= ptr_d;
                            tdata_q <= mem[ptr_d];
                            tlast_q <= tlast_d;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign len_err       = len_err_q;
    assign beat_count    = beat_count_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule
